// File: rtl/cpu_pkg.sv
// Shared encodings, FSM state type and sizing helper for the memory stage.
package cpu_pkg;

  // Load kinds carried on exe_ld_op; other codes are illegal.
  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;
  localparam logic [2:0] LD_LWU = 3'd5;
  localparam logic [2:0] LD_LD  = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
  } mem_state_e;

  // Bits needed to count 0..max_outst discarded responses.
  function automatic int discard_cnt_width(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word/dword out of a memory word and extends it.
module load_align
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       ld_op,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Size casts of signed operands sign-extend; unsigned ones zero-extend.
  // With XLEN=32 LWU collapses to a plain word and LD to the full word.
  always_comb begin
    data = '0;
    case (ld_op)
      LD_LB:   data = XLEN'($signed(shifted[7:0]));
      LD_LBU:  data = XLEN'(shifted[7:0]);
      LD_LH:   data = XLEN'($signed(shifted[15:0]));
      LD_LHU:  data = XLEN'(shifted[15:0]);
      LD_LW:   data = XLEN'($signed(shifted[31:0]));
      LD_LWU:  data = XLEN'(shifted[31:0]);
      LD_LD:   data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory pipeline stage: holds one instruction, waits for load data, hands off to WB.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_EMPTY | no instruction held
// ST_WAIT  | load issued, waiting for its data_ok
// ST_DONE  | result in the result register, offered to WB
//
// Responses for loads flushed while in ST_WAIT still arrive later; the
// discard counter tracks how many must be swallowed before a data_ok
// belongs to the current entry again.
module mem_stage_lsu
  import cpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int DEST_W    = 5,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_valid,
  output logic              mem_allow_in,
  input  logic [PC_W-1:0]   exe_pc,
  input  logic [XLEN-1:0]   exe_alu_result,
  input  logic [2:0]        exe_ld_op,
  input  logic              exe_res_from_mem,
  input  logic              exe_req_sent,
  input  logic              exe_gr_we,
  input  logic [DEST_W-1:0] exe_dest,
  input  logic              data_ok,
  input  logic [XLEN-1:0]   rdata,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_allow_in,
  output logic [PC_W-1:0]   wb_pc,
  output logic [XLEN-1:0]   wb_result,
  output logic              wb_gr_we,
  output logic [DEST_W-1:0] wb_dest,
  output logic              fwd_we,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [XLEN-1:0]   fwd_data,
  output logic              fwd_pending
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = discard_cnt_width(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  mem_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PC_W-1:0]   pc_reg;
  logic [XLEN-1:0]   result_reg;
  logic [2:0]        ld_op_reg;
  logic              gr_we_reg;
  logic [DEST_W-1:0] dest_reg;
  logic [XLEN-1:0]   load_data;
  logic              accept, own_resp, drop, lost;

  // While waiting, result_reg still holds the load address, so its low bits
  // select the lane when the data arrives.
  load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_load_align (
    .ld_op  (ld_op_reg),
    .offset (result_reg[OFF_W-1:0]),
    .rdata  (rdata),
    .data   (load_data)
  );

  assign own_resp = (state == ST_WAIT) && data_ok && (cnt == '0);
  assign drop     = data_ok && (cnt != '0);
  // A flush in WAIT abandons a response still in flight, unless it lands now.
  assign lost     = flush && (state == ST_WAIT) && !own_resp;
  assign accept   = exe_valid && mem_allow_in && !flush;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  // Next state, discard-counter update and stage outputs.
  // The counter limit wins over flush so the counter can never overflow.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    mem_allow_in = 1'b0;
    wb_valid     = 1'b0;
    fwd_we       = 1'b0;
    fwd_pending  = 1'b0;
    fwd_data     = result_reg;

    if (cnt != CNT_MAX)
      mem_allow_in = flush || (state == ST_EMPTY) || ((state == ST_DONE) && wb_allow_in);

    if (flush)       state_nxt = ST_EMPTY;
    else if (accept) state_nxt = (exe_res_from_mem && exe_req_sent) ? ST_WAIT : ST_DONE;
    else begin
      case (state)
        ST_WAIT: if (own_resp)    state_nxt = ST_DONE;
        ST_DONE: if (wb_allow_in) state_nxt = ST_EMPTY;
        default: state_nxt = state;
      endcase
    end

    if (drop && !lost)      cnt_nxt = cnt - CNT_W'(1);
    else if (lost && !drop) cnt_nxt = cnt + CNT_W'(1);

    wb_valid = (state == ST_DONE);
    fwd_we   = (state != ST_EMPTY) && gr_we_reg;
    if (state == ST_WAIT) begin
      fwd_pending = 1'b1;
      fwd_data    = '0;
    end
  end

  // Discard counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  // Payload: latch EXE fields on accept, overwrite the result with load data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= '0;
      result_reg <= '0;
      ld_op_reg  <= '0;
      gr_we_reg  <= 1'b0;
      dest_reg   <= '0;
    end else if (accept) begin
      pc_reg     <= exe_pc;
      result_reg <= exe_alu_result;
      ld_op_reg  <= exe_ld_op;
      gr_we_reg  <= exe_gr_we;
      dest_reg   <= exe_dest;
    end else if (own_resp && !flush) begin
      result_reg <= load_data;
    end
  end

  assign wb_pc     = pc_reg;
  assign wb_result = result_reg;
  assign wb_gr_we  = gr_we_reg;
  assign wb_dest   = dest_reg;
  assign fwd_dest  = dest_reg;

endmodule
